// File: rtl/chacha_stream_xor.sv
// ChaCha keystream consumer: XORs 512-bit keystream blocks onto a 32-bit word stream.
// One block is requested per 16 words; a single output register gives 1-cycle latency at full rate.
module chacha_stream_xor #(
  parameter int WORD_COUNT = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [31:0]              counter_init_i,
  output logic                     ks_req_o,
  output logic [31:0]              ks_counter_o,
  input  logic                     ks_valid_i,
  input  logic [WORD_COUNT*32-1:0] keystream_i,
  input  logic                     din_valid_i,
  output logic                     din_ready_o,
  input  logic [31:0]              din_i,
  input  logic [3:0]               din_keep_i,
  input  logic                     din_last_i,
  output logic                     dout_valid_o,
  input  logic                     dout_ready_i,
  output logic [31:0]              dout_o,
  output logic [3:0]               dout_keep_o,
  output logic                     dout_last_o,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int IDX_W = $clog2(WORD_COUNT);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, ERR} state_e;

  state_e                  state_q, state_d;
  logic [WORD_COUNT*32-1:0] ks_buf_q, ks_buf_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [31:0]             ks_ctr_q, ks_ctr_d;
  logic [31:0]             dout_q, dout_d;
  logic [3:0]              keep_q, keep_d;
  logic                    last_q, last_d;
  logic                    dvld_q, dvld_d;
  logic                    err_q, err_d;

  logic                    din_rdy;
  logic                    din_acc;
  logic                    dout_hs;
  logic [IDX_W+4:0]        ks_sel;
  logic [31:0]             ks_word;
  logic [31:0]             byte_mask;

  assign din_rdy = (state_q == STREAM) && (!dvld_q || dout_ready_i);
  assign din_acc = din_valid_i && din_rdy;
  assign dout_hs = dvld_q && dout_ready_i;

  // RFC word 0 sits in the top 32 bits, so word idx starts at bit (15-idx)*32.
  assign ks_sel    = {~idx_q, 5'b0};
  assign ks_word   = ks_buf_q[ks_sel +: 32];
  assign byte_mask = {{8{din_keep_i[3]}}, {8{din_keep_i[2]}},
                      {8{din_keep_i[1]}}, {8{din_keep_i[0]}}};

  always_comb begin
    state_d  = state_q;
    ks_buf_d = ks_buf_q;
    idx_d    = idx_q;
    ks_ctr_d = ks_ctr_q;
    dout_d   = dout_q;
    keep_d   = keep_q;
    last_d   = last_q;
    dvld_d   = dvld_q;
    err_d    = err_q;

    case (state_q)
      IDLE, ERR: begin
        if (start_i) begin
          state_d  = FETCH;
          ks_ctr_d = counter_init_i;
          err_d    = 1'b0;
        end
      end
      FETCH: begin
        if (ks_valid_i) begin
          ks_buf_d = keystream_i;
          idx_d    = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (din_acc) begin
          if (din_last_i) begin
            state_d = IDLE;
          end else if (idx_q == IDX_W'(WORD_COUNT - 1)) begin
            idx_d = '0;
            // Block counter never wraps: a wrap would reuse keystream.
            if (ks_ctr_q == 32'hFFFF_FFFF) begin
              state_d = ERR;
              err_d   = 1'b1;
            end else begin
              ks_ctr_d = ks_ctr_q + 32'd1;
              state_d  = FETCH;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (din_acc) begin
      dout_d = (din_i ^ ks_word) & byte_mask;
      keep_d = din_keep_i;
      last_d = din_last_i;
      dvld_d = 1'b1;
    end else if (dout_hs) begin
      dvld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ks_buf_q <= '0;
      idx_q    <= '0;
      ks_ctr_q <= '0;
      dout_q   <= '0;
      keep_q   <= '0;
      last_q   <= 1'b0;
      dvld_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ks_buf_q <= ks_buf_d;
      idx_q    <= idx_d;
      ks_ctr_q <= ks_ctr_d;
      dout_q   <= dout_d;
      keep_q   <= keep_d;
      last_q   <= last_d;
      dvld_q   <= dvld_d;
      err_q    <= err_d;
    end
  end

  assign ks_req_o     = (state_q == FETCH);
  assign ks_counter_o = ks_ctr_q;
  assign din_ready_o  = din_rdy;
  assign dout_valid_o = dvld_q;
  assign dout_o       = dout_q;
  assign dout_keep_o  = keep_q;
  assign dout_last_o  = last_q;
  assign busy_o       = (state_q != IDLE) || dvld_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_chacha_stream_xor.sv
// Bench for chacha_stream_xor: a ChaCha20 reference model feeds keystream, a scoreboard checks output words.
module tb_chacha_stream_xor;

  typedef logic [15:0][31:0] st_t;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic [31:0]  counter_init_i;
  logic         ks_req_o;
  logic [31:0]  ks_counter_o;
  logic         ks_valid_i;
  logic [511:0] keystream_i;
  logic         din_valid_i;
  logic         din_ready_o;
  logic [31:0]  din_i;
  logic [3:0]   din_keep_i;
  logic         din_last_i;
  logic         dout_valid_o;
  logic         dout_ready_i;
  logic [31:0]  dout_o;
  logic [3:0]   dout_keep_o;
  logic         dout_last_o;
  logic         busy_o;
  logic         err_o;

  chacha_stream_xor #(.WORD_COUNT(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .counter_init_i(counter_init_i),
    .ks_req_o(ks_req_o), .ks_counter_o(ks_counter_o), .ks_valid_i(ks_valid_i),
    .keystream_i(keystream_i), .din_valid_i(din_valid_i), .din_ready_o(din_ready_o),
    .din_i(din_i), .din_keep_i(din_keep_i), .din_last_i(din_last_i),
    .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i), .dout_o(dout_o),
    .dout_keep_o(dout_keep_o), .dout_last_o(dout_last_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m_dat[$];
  logic [3:0]  m_keep[$];
  logic        m_last[$];
  logic [36:0] exp_q[$];
  logic [31:0] exp_ctr[$];
  logic [31:0] m_ctr0 = '0;
  int          m_mode = 0;
  int          ptr = 0;
  int          n_out = 0;
  bit          rdy_rand = 0, gap_rand = 0, junk_ks = 0, start_req = 0, chk_rfc = 0;
  bit          pend = 0, held_vld = 0;
  logic [36:0] held = '0;
  logic [31:0] last_dout = '0;
  string       pt;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic st_t qr(input st_t xi, input int a, input int b, input int c, input int d);
    st_t x;
    x = xi;
    x[a] = x[a] + x[b]; x[d] = x[d] ^ x[a]; x[d] = {x[d][15:0], x[d][31:16]};
    x[c] = x[c] + x[d]; x[b] = x[b] ^ x[c]; x[b] = {x[b][19:0], x[b][31:20]};
    x[a] = x[a] + x[b]; x[d] = x[d] ^ x[a]; x[d] = {x[d][23:0], x[d][31:24]};
    x[c] = x[c] + x[d]; x[b] = x[b] ^ x[c]; x[b] = {x[b][24:0], x[b][31:25]};
    return x;
  endfunction

  // RFC 8439 2.4.2 key (00..1f) and nonce; returns block laid out as keystream_i.
  function automatic st_t chacha_block(input logic [31:0] ctr);
    st_t s, x, o;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    s[12] = ctr; s[13] = 32'h0; s[14] = 32'h4a000000; s[15] = 32'h0;
    x = s;
    for (int r = 0; r < 10; r++) begin
      x = qr(x, 0, 4, 8, 12); x = qr(x, 1, 5, 9, 13); x = qr(x, 2, 6, 10, 14); x = qr(x, 3, 7, 11, 15);
      x = qr(x, 0, 5, 10, 15); x = qr(x, 1, 6, 11, 12); x = qr(x, 2, 7, 8, 13); x = qr(x, 3, 4, 9, 14);
    end
    for (int j = 0; j < 16; j++) o[15-j] = x[j] + s[j];
    return o;
  endfunction

  function automatic st_t ks_fn(input logic [31:0] ctr);
    if (m_mode == 1) return '0;
    return chacha_block(ctr);
  endfunction

  function automatic logic [31:0] kmask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  function automatic logic [36:0] exp_entry(input int k);
    st_t         blk;
    logic [31:0] w;
    blk = ks_fn(m_ctr0 + 32'(k / 16));
    w   = blk[15 - (k % 16)];
    return {(m_dat[k] ^ w) & kmask(m_keep[k]), m_keep[k], m_last[k]};
  endfunction

  task automatic load_msg(input int n, input logic [31:0] ctr, input int mode);
    m_dat.delete(); m_keep.delete(); m_last.delete(); exp_q.delete(); exp_ctr.delete();
    for (int i = 0; i < n; i++) begin
      m_dat.push_back($urandom());
      m_keep.push_back(4'hF);
      m_last.push_back(i == n - 1);
    end
    m_ctr0 = ctr; m_mode = mode; ptr = 0; n_out = 0; pend = 0;
  endtask

  task automatic step();
    logic [36:0] e;
    @(negedge clk_i);
    start_i        = start_req;
    start_req      = 0;
    counter_init_i = m_ctr0;
    dout_ready_i   = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    ks_valid_i     = 1'b0;
    if (ks_req_o) begin
      if (exp_ctr.size() > 0) check_eq("ks_ctr", 64'(ks_counter_o), 64'(exp_ctr.pop_front()));
      else check_eq("ks_extra_req", 64'(ks_req_o), 64'd0);
      ks_valid_i  = 1'b1;
      keystream_i = ks_fn(ks_counter_o);
    end else if (junk_ks && $urandom_range(0, 3) == 0) begin
      ks_valid_i  = 1'b1;
      keystream_i = ~ks_fn(ks_counter_o);
    end
    if (ptr < m_dat.size() && (pend || !gap_rand || $urandom_range(0, 3) != 0)) begin
      din_valid_i = 1'b1; din_i = m_dat[ptr]; din_keep_i = m_keep[ptr]; din_last_i = m_last[ptr];
    end else begin
      din_valid_i = 1'b0; din_i = $urandom(); din_keep_i = 4'h0; din_last_i = 1'b0;
    end
    #1;
    if (held_vld) check_eq("hold", 64'({dout_o, dout_keep_o, dout_last_o}), 64'(held));
    held_vld = dout_valid_o && !dout_ready_i;
    held     = {dout_o, dout_keep_o, dout_last_o};
    if (dout_valid_o && !dout_ready_i) check_eq("rdy_when_full", 64'(din_ready_o), 64'd0);
    if (dout_valid_o && dout_ready_i) begin
      if (exp_q.size() == 0) check_eq("dout_dup", 64'(dout_valid_o), 64'd0);
      else begin
        e = exp_q.pop_front();
        check_eq("dout", 64'({dout_o, dout_keep_o, dout_last_o}), 64'(e));
        if (chk_rfc && n_out == 0) check_eq("rfc_word0", 64'(dout_o), 64'h9A352E6E);
        last_dout = dout_o;
        n_out++;
      end
    end
    pend = din_valid_i && !din_ready_o;
    if (din_valid_i && din_ready_o) begin
      exp_q.push_back(exp_entry(ptr));
      ptr++;
    end
  endtask

  task automatic run(input int target, input int budget, input string tag);
    int c = 0;
    while (!(ptr >= target && exp_q.size() == 0 && !dout_valid_o) && c < budget) begin
      step();
      c++;
    end
    check_eq(tag, 64'(c < budget), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctr"},  64'(ks_counter_o), 64'd0);
    check_eq({tag, "_dvld"}, 64'(dout_valid_o), 64'd0);
    check_eq({tag, "_dout"}, 64'({dout_o, dout_keep_o, dout_last_o}), 64'd0);
    check_eq({tag, "_err"},  64'(err_o), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy_o), 64'd0);
    check_eq({tag, "_req"},  64'(ks_req_o), 64'd0);
    check_eq({tag, "_rdy"},  64'(din_ready_o), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    rst_ni = 1'b0; start_i = 0; counter_init_i = '0; ks_valid_i = 0; keystream_i = '0;
    din_valid_i = 0; din_i = '0; din_keep_i = '0; din_last_i = 0; dout_ready_i = 0;
    repeat (2) @(negedge clk_i);
    #1 check_all_zero("reset");
    @(negedge clk_i) rst_ni = 1'b1;

    // RFC 8439 sunscreen message, unused tail bytes of the last word carry junk
    pt = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
    load_msg((pt.len() + 3) / 4, 32'd1, 0);
    for (int k = 0; k < m_dat.size(); k++)
      for (int j = 0; j < 4; j++) begin
        b = (4*k + j < pt.len()) ? pt[4*k + j] : 8'hAB;
        m_dat[k][8*j +: 8] = b;
      end
    m_keep[m_keep.size() - 1] = 4'b0011;
    exp_ctr.push_back(32'd1); exp_ctr.push_back(32'd2);
    chk_rfc = 1; start_req = 1;
    run(29, 400, "sun_done");
    chk_rfc = 0;
    check_eq("sun_words", 64'(n_out), 64'd29);
    check_eq("sun_reqs_left", 64'(exp_ctr.size()), 64'd0);

    // Random backpressure, input gaps and stray ks_valid pulses
    load_msg(40, 32'hCAFE0010, 0);
    for (int i = 0; i < 3; i++) exp_ctr.push_back(32'hCAFE0010 + 32'(i));
    rdy_rand = 1; gap_rand = 1; junk_ks = 1; start_req = 1;
    run(40, 2000, "bp_done");
    rdy_rand = 0; gap_rand = 0; junk_ks = 0;
    check_eq("bp_words", 64'(n_out), 64'd40);
    check_eq("bp_reqs_left", 64'(exp_ctr.size()), 64'd0);

    // Message ending exactly on a block boundary
    load_msg(16, 32'd7, 0);
    exp_ctr.push_back(32'd7);
    start_req = 1;
    run(16, 300, "bnd_done");
    repeat (3) step();
    check_eq("bnd_words", 64'(n_out), 64'd16);
    check_eq("bnd_busy", 64'(busy_o), 64'd0);
    check_eq("bnd_req", 64'(ks_req_o), 64'd0);
    check_eq("bnd_reqs_left", 64'(exp_ctr.size()), 64'd0);

    // Counter overflow stops after the first block
    load_msg(17, 32'hFFFFFFFF, 0);
    exp_ctr.push_back(32'hFFFFFFFF);
    start_req = 1;
    run(16, 300, "ovf_16");
    repeat (10) step();
    check_eq("ovf_no_w17", 64'(ptr), 64'd16);
    check_eq("ovf_err", 64'(err_o), 64'd1);
    check_eq("ovf_req", 64'(ks_req_o), 64'd0);
    check_eq("ovf_rdy", 64'(din_ready_o), 64'd0);
    check_eq("ovf_busy", 64'(busy_o), 64'd1);
    load_msg(3, 32'd5, 0);
    exp_ctr.push_back(32'd5);
    start_req = 1;
    repeat (2) step();
    check_eq("ovf_err_clr", 64'(err_o), 64'd0);
    run(3, 200, "ovf_restart");
    check_eq("ovf_restart_words", 64'(n_out), 64'd3);

    // Asynchronous reset in the middle of a message
    load_msg(20, 32'd100, 0);
    exp_ctr.push_back(32'd100); exp_ctr.push_back(32'd101);
    start_req = 1;
    for (int c = 0; c < 200 && ptr < 7; c++) step();
    @(negedge clk_i);
    #1 check_eq("rst_pre_vld", 64'(dout_valid_o), 64'd1);
    rst_ni = 1'b0; din_valid_i = 1'b0; ks_valid_i = 1'b0;
    #1 check_all_zero("rst_mid");
    exp_q.delete(); exp_ctr.delete(); held_vld = 0; pend = 0;
    @(negedge clk_i) rst_ni = 1'b1;
    load_msg(5, 32'd200, 0);
    exp_ctr.push_back(32'd200);
    start_req = 1;
    run(5, 200, "rst_restart");
    check_eq("rst_restart_words", 64'(n_out), 64'd5);
    check_eq("rst_reqs_left", 64'(exp_ctr.size()), 64'd0);

    // All-zero keystream: output is the masked input
    load_msg(3, 32'd3, 1);
    m_keep[2] = 4'b0001;
    exp_ctr.push_back(32'd3);
    start_req = 1;
    run(3, 200, "zero_done");
    check_eq("zero_last", 64'(last_dout), 64'(m_dat[2] & 32'h000000FF));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
